// File: rtl/uram_readout_scheduler.sv
// uram_readout_scheduler
//   Shares the URAM event readout state machine between event readout and
//   firmware loading. It tracks how many URAM buffers hold complete events
//   (write pointer) and which buffer is read next (read pointer). It drives
//   data_available / fw_loading into the readout SM and consumes its
//   complete flag. It also raises sticky overflow, spurious-complete and
//   readout-timeout errors.
//
// Ports
//   clk_i, rst_i        readout clock, async active-high reset
//   clk_ce_i            readout SM clock enable, counted while draining
//   ev_done_i           writer finished an event in buffer wr_buf_o
//   wr_buf_o, rd_buf_o  write / read buffer indices
//   full_o, pending_o   occupancy (events written, not yet read out)
//   data_available_o    to readout SM: an event is ready to read
//   complete_i          from readout SM: current event read out
//   fw_req_i            level request for a firmware load
//   fw_loading_o        to readout SM: firmware load in progress
//   ev_count_o          events read out, wraps
//   err_o               sticky {timeout, spurious_complete, overflow}
//   err_clr_i           clears err_o
module uram_readout_scheduler #(
  parameter int NBUF         = 4,
  parameter int FW_PRIORITY  = 0,
  parameter int TIMEOUT_CLKS = 65535,
  parameter int DRAIN_CES    = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    clk_ce_i,
  input  logic                    ev_done_i,
  output logic [$clog2(NBUF)-1:0] wr_buf_o,
  output logic                    full_o,
  output logic [$clog2(NBUF):0]   pending_o,
  output logic [$clog2(NBUF)-1:0] rd_buf_o,
  output logic                    data_available_o,
  input  logic                    complete_i,
  input  logic                    fw_req_i,
  output logic                    fw_loading_o,
  output logic [15:0]             ev_count_o,
  output logic [2:0]              err_o,
  input  logic                    err_clr_i
);

  localparam int PW = $clog2(NBUF);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam int DW = (DRAIN_CES > 1) ? $clog2(DRAIN_CES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_FW, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]     pend_q, pend_d;
  logic            full_q, full_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      err_q, err_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [DW-1:0]   drn_q, drn_d;
  logic            da_q, da_d, fw_q, fw_d;

  logic rd_done, wr_ok, ovf, spur, tmo_hit, is_full;

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    drn_d   = drn_q;
    tmo_hit = 1'b0;

    is_full = (pend_q == (PW+1)'(NBUF));
    rd_done = complete_i && (state_q == S_READ);
    spur    = complete_i && (state_q != S_READ);
    // A same-cycle read frees a slot, so a write into a full buffer set is legal then.
    wr_ok   = ev_done_i && (!is_full || rd_done);
    ovf     = ev_done_i && is_full && !rd_done;

    if (wr_ok)   wr_d = wr_q + PW'(1);
    if (rd_done) begin
      rd_d  = rd_q + PW'(1);
      cnt_d = cnt_q + 16'd1;
    end
    if (wr_ok && !rd_done)      pend_d = pend_q + (PW+1)'(1);
    else if (!wr_ok && rd_done) pend_d = pend_q - (PW+1)'(1);

    unique case (state_q)
      S_IDLE: begin
        if (fw_req_i && (pend_q == '0 || FW_PRIORITY != 0)) state_d = S_FW;
        else if (pend_q != '0)                              state_d = S_READ;
      end
      S_READ: begin
        // Saturating counter so the timeout error fires only once per READ visit.
        if (tmo_q != TW'(TIMEOUT_CLKS)) begin
          tmo_d = tmo_q + TW'(1);
          if (tmo_d == TW'(TIMEOUT_CLKS)) tmo_hit = 1'b1;
        end
        if (rd_done) state_d = S_IDLE;
      end
      S_FW: begin
        if (!fw_req_i) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Give the readout SM time to fall back to its header state.
        if (clk_ce_i) begin
          if (drn_q == DW'(DRAIN_CES - 1)) state_d = S_IDLE;
          else                             drn_d = drn_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_READ && state_d == S_READ)  tmo_d = '0;
    if (state_q != S_DRAIN && state_d == S_DRAIN) drn_d = '0;

    full_d = (pend_d == (PW+1)'(NBUF));
    da_d   = (state_d == S_READ);
    fw_d   = (state_d == S_FW);
    // Clear first, then OR in new errors so a same-cycle error survives the clear.
    err_d  = (err_clr_i ? 3'b000 : err_q) | {tmo_hit, spur, ovf};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      pend_q  <= '0;
      full_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= '0;
      tmo_q   <= '0;
      drn_q   <= '0;
      da_q    <= 1'b0;
      fw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      pend_q  <= pend_d;
      full_q  <= full_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      drn_q   <= drn_d;
      da_q    <= da_d;
      fw_q    <= fw_d;
    end
  end

  assign wr_buf_o         = wr_q;
  assign rd_buf_o         = rd_q;
  assign pending_o        = pend_q;
  assign full_o           = full_q;
  assign ev_count_o       = cnt_q;
  assign err_o            = err_q;
  assign data_available_o = da_q;
  assign fw_loading_o     = fw_q;

endmodule

// File: tb/tb_uram_readout_scheduler.sv
module tb_uram_readout_scheduler;
  localparam int NBUF = 4;

  logic        clk_i = 1'b0, rst_i = 1'b1, clk_ce_i = 1'b0, ev_done_i = 1'b0;
  logic        complete_i = 1'b0, fw_req_i = 1'b0, err_clr_i = 1'b0;
  logic [1:0]  wr_buf_o, rd_buf_o;
  logic        full_o, data_available_o, fw_loading_o;
  logic [2:0]  pending_o;
  logic [15:0] ev_count_o;
  logic [2:0]  err_o;

  uram_readout_scheduler #(
    .NBUF(NBUF), .FW_PRIORITY(0), .TIMEOUT_CLKS(16), .DRAIN_CES(2)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clk_ce_i(clk_ce_i), .ev_done_i(ev_done_i),
    .wr_buf_o(wr_buf_o), .full_o(full_o), .pending_o(pending_o), .rd_buf_o(rd_buf_o),
    .data_available_o(data_available_o), .complete_i(complete_i), .fw_req_i(fw_req_i),
    .fw_loading_o(fw_loading_o), .ev_count_o(ev_count_o), .err_o(err_o), .err_clr_i(err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0, fails = 0;
  typedef struct { int rd; int cnt; } exp_t;
  exp_t sb[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic pulse_ev();
    ev_done_i = 1'b1; step(); ev_done_i = 1'b0;
  endtask

  task automatic wait_da(input string nm);
    for (int n = 0; n < 20 && !data_available_o; n++) step();
    check(nm, 32'(data_available_o), 1);
  endtask

  // Expected rd_buf/ev_count after this readout goes into the scoreboard.
  task automatic do_read(input int rd, input int cnt);
    exp_t e;
    wait_da("da_before_read");
    e.rd = rd; e.cnt = cnt;
    sb.push_back(e);
    complete_i = 1'b1; step(); complete_i = 1'b0;
    check("da_drop_after_complete", 32'(data_available_o), 0);
  endtask

  // Monitor: each falling edge of data_available_o is one finished readout.
  initial begin
    logic da_prev;
    exp_t e;
    da_prev = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i) da_prev = 1'b0;
      else begin
        check("da_fw_exclusive", 32'(data_available_o & fw_loading_o), 0);
        if (da_prev && !data_available_o) begin
          if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL sb_underflow: readout seen, none expected");
          end else begin
            e = sb.pop_front();
            check("sb_rd_buf", 32'(rd_buf_o), e.rd);
            check("sb_ev_count", 32'(ev_count_o), e.cnt);
          end
        end
        da_prev = data_available_o;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    step(); step();
    check("rst_wr_buf", 32'(wr_buf_o), 0);
    check("rst_rd_buf", 32'(rd_buf_o), 0);
    check("rst_pending", 32'(pending_o), 0);
    check("rst_full", 32'(full_o), 0);
    check("rst_da", 32'(data_available_o), 0);
    check("rst_fw", 32'(fw_loading_o), 0);
    check("rst_ev_count", 32'(ev_count_o), 0);
    check("rst_err", 32'(err_o), 0);
    rst_i = 1'b0;
    step();

    // Three events, three readouts
    for (int i = 0; i < 3; i++) pulse_ev();
    check("t1_wr_buf", 32'(wr_buf_o), 3);
    for (int i = 0; i < 3; i++) begin
      do_read(i + 1, i + 1);
      if (i < 2) begin
        step();
        check("t1_da_reassert", 32'(data_available_o), 1);
      end
    end
    step();
    check("t1_da_idle", 32'(data_available_o), 0);
    check("t1_pending", 32'(pending_o), 0);
    check("t1_rd_buf", 32'(rd_buf_o), 3);
    check("t1_ev_count", 32'(ev_count_o), 3);

    // Overflow: 5 writes with no reads
    rst_i = 1'b1; step(); rst_i = 1'b0;
    for (int i = 0; i < 4; i++) pulse_ev();
    check("t2_full", 32'(full_o), 1);
    check("t2_pending4", 32'(pending_o), 4);
    check("t2_err_none", 32'(err_o), 0);
    pulse_ev();
    check("t2_err_ovf", 32'(err_o), 1);
    check("t2_pending_hold", 32'(pending_o), 4);
    check("t2_wr_buf", 32'(wr_buf_o), 0);

    // Full with simultaneous write and read
    err_clr_i = 1'b1; step(); err_clr_i = 1'b0;
    check("t3_err_clr", 32'(err_o), 0);
    check("t3_da_before", 32'(data_available_o), 1);
    begin
      exp_t e;
      e.rd = 1; e.cnt = 1;
      sb.push_back(e);
    end
    ev_done_i = 1'b1; complete_i = 1'b1; step(); ev_done_i = 1'b0; complete_i = 1'b0;
    check("t3_pending", 32'(pending_o), 4);
    check("t3_no_ovf", 32'(err_o), 0);
    check("t3_wr_buf", 32'(wr_buf_o), 1);
    check("t3_rd_buf", 32'(rd_buf_o), 1);
    check("t3_full", 32'(full_o), 1);
    for (int i = 0; i < 4; i++) do_read((2 + i) % 4, 2 + i);
    check("t3_pending_empty", 32'(pending_o), 0);
    check("t3_not_full", 32'(full_o), 0);
    check("t3_ptrs_equal", 32'(wr_buf_o), 32'(rd_buf_o));

    // Firmware request waits for the pending read, then drains
    pulse_ev();
    fw_req_i = 1'b1; step();
    check("t4_read_first", 32'(data_available_o), 1);
    step(); step(); step();
    check("t4_fw_waits", 32'(fw_loading_o), 0);
    do_read(2, 6);
    step();
    check("t4_fw_on", 32'(fw_loading_o), 1);
    check("t4_da_off", 32'(data_available_o), 0);
    pulse_ev();
    step();
    check("t4_fw_hold", 32'(fw_loading_o), 1);
    check("t4_pending1", 32'(pending_o), 1);
    fw_req_i = 1'b0; step();
    check("t4_fw_off", 32'(fw_loading_o), 0);
    step(); step();
    check("t4_drain_no_ce", 32'(data_available_o), 0);
    clk_ce_i = 1'b1; step(); clk_ce_i = 1'b0;
    check("t4_drain_ce1", 32'(data_available_o), 0);
    clk_ce_i = 1'b1; step(); clk_ce_i = 1'b0;
    check("t4_drain_ce2", 32'(data_available_o), 0);
    step();
    check("t4_da_after_drain", 32'(data_available_o), 1);
    do_read(3, 7);

    // Readout timeout
    pulse_ev();
    step();
    check("t5_in_read", 32'(data_available_o), 1);
    repeat (15) step();
    check("t5_no_tmo_yet", 32'(err_o), 0);
    step();
    check("t5_tmo", 32'(err_o), 4);
    err_clr_i = 1'b1; step(); err_clr_i = 1'b0;
    check("t5_tmo_clr", 32'(err_o), 0);
    step(); step(); step();
    check("t5_tmo_once", 32'(err_o), 0);
    check("t5_still_read", 32'(data_available_o), 1);
    do_read(0, 8);
    check("t5_err_after", 32'(err_o), 0);

    // Spurious complete in IDLE
    step();
    complete_i = 1'b1; step(); complete_i = 1'b0;
    check("t6_spurious", 32'(err_o), 2);
    check("t6_ev_count", 32'(ev_count_o), 8);
    check("t6_rd_buf", 32'(rd_buf_o), 0);
    err_clr_i = 1'b1; step(); err_clr_i = 1'b0;
    check("t6_clr", 32'(err_o), 0);

    // Reset mid-READ and mid-FW
    pulse_ev();
    step();
    check("t7_in_read", 32'(data_available_o), 1);
    rst_i = 1'b1; #1;
    check("t7_da_async", 32'(data_available_o), 0);
    check("t7_pending", 32'(pending_o), 0);
    check("t7_wr_buf", 32'(wr_buf_o), 0);
    check("t7_ev_count", 32'(ev_count_o), 0);
    step(); rst_i = 1'b0;
    fw_req_i = 1'b1; step();
    check("t7_fw_on", 32'(fw_loading_o), 1);
    rst_i = 1'b1; #1;
    check("t7_fw_async", 32'(fw_loading_o), 0);
    fw_req_i = 1'b0; step(); rst_i = 1'b0; step();

    check("sb_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
